pipelined_decode_unit: RTL and testbench

Parametrised next-generation instruction decoder for the MIPS core: the combinational opcode/funct decode feeds a registered ID/EX control bundle with stall and flush handshakes. It adds sub-word memory decode (LBU/LHU/SB/SH), a sticky halt that blocks further issue, `$zero` write suppression, and saturating illegal-instruction accounting. It sits between the IF/ID latch and the execute stage, and replaces the single-cycle control path in pipelined builds.

---
 rtl/pipelined_decode_unit_if.sv | 108 ++++++++++
 rtl/pipelined_decode_unit.sv | 206 ++++++++++++++++++++
 tb/tb_pipelined_decode_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_decode_unit_if.sv
// Shared decode types and the IF/ID -> ID/EX bundle interface of the pipelined decoder.
// The package carries the ALU encoding, opcodes and the registered ID/EX slot layout.
package pipelined_decode_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25, OP_SB    = 6'h28, OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B, OP_LL    = 6'h30, OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        memto_reg;
        logic        alu_src;
        logic        wdata_src;
        logic        branch;
        logic        branch_sel;
        logic        datomic;
        logic        dren;
        logic        dwen;
        logic [1:0]  pc_sel;
        aluop_t      alu_op;
        logic [4:0]  rsel1;
        logic [4:0]  rsel2;
        logic [4:0]  wsel;
        logic [31:0] imm;
        logic [1:0]  memsize;
        logic [31:0] npc;
    } idex_t;

    function automatic idex_t bubble_f();
        idex_t b;
        b        = '0;
        b.pc_sel = 2'b11;
        return b;
    endfunction

endpackage

interface pipelined_decode_unit_if #(parameter int ILL_CNT_W = 8);
    logic [31:0]                     instr;
    logic                            instr_valid;
    logic [31:0]                     npc;
    logic                            stall;
    logic                            flush;
    logic [4:0]                      id_rsel1;
    logic [4:0]                      id_rsel2;
    logic                            accept;
    logic                            ex_valid;
    logic                            ex_regWrite;
    logic                            ex_memtoReg;
    logic                            ex_aluSrc;
    logic                            ex_wdataSrc;
    logic                            ex_branch;
    logic                            ex_branchSel;
    logic                            ex_datomic;
    logic                            ex_dREN;
    logic                            ex_dWEN;
    logic [1:0]                      ex_PCSel;
    pipelined_decode_pkg::aluop_t    ex_ALUop;
    logic [4:0]                      ex_rsel1;
    logic [4:0]                      ex_rsel2;
    logic [4:0]                      ex_wsel;
    logic [31:0]                     ex_immediate;
    logic [1:0]                      ex_memsize;
    logic [31:0]                     ex_npc;
    logic                            halt;
    logic                            illegal;
    logic [ILL_CNT_W-1:0]            illegal_count;

    modport master (
        output instr, instr_valid, npc, stall, flush,
        input  id_rsel1, id_rsel2, accept, ex_valid, ex_regWrite, ex_memtoReg, ex_aluSrc,
               ex_wdataSrc, ex_branch, ex_branchSel, ex_datomic, ex_dREN, ex_dWEN, ex_PCSel,
               ex_ALUop, ex_rsel1, ex_rsel2, ex_wsel, ex_immediate, ex_memsize, ex_npc,
               halt, illegal, illegal_count
    );

    modport slave (
        input  instr, instr_valid, npc, stall, flush,
        output id_rsel1, id_rsel2, accept, ex_valid, ex_regWrite, ex_memtoReg, ex_aluSrc,
               ex_wdataSrc, ex_branch, ex_branchSel, ex_datomic, ex_dREN, ex_dWEN, ex_PCSel,
               ex_ALUop, ex_rsel1, ex_rsel2, ex_wsel, ex_immediate, ex_memsize, ex_npc,
               halt, illegal, illegal_count
    );
endinterface

// File: rtl/pipelined_decode_unit.sv
// Pipelined MIPS decoder: combinational opcode/funct decode into a registered ID/EX bundle
// with stall/flush handling, sticky halt and saturating illegal-instruction accounting.
module pipelined_decode_unit
    import pipelined_decode_pkg::*;
#(
    parameter bit SUBWORD_EN = 1'b1,
    parameter int ILL_CNT_W  = 8
) (
    input logic                     CLK,
    input logic                     nRST,
    pipelined_decode_unit_if.slave  bus
);

    logic [5:0]           opcode_s;
    logic [5:0]           funct_s;
    logic [4:0]           rs_s, rt_s, rd_s, shamt_s;
    logic [15:0]          imm_s;
    logic                 ill_s;
    logic                 halt_op_s;
    logic                 accept_s;
    idex_t                dec_s;
    idex_t                idex_r;
    logic                 halt_r;
    logic                 ill_r;
    logic [ILL_CNT_W-1:0] ill_cnt_r;

    assign opcode_s = bus.instr[31:26];
    assign rs_s     = bus.instr[25:21];
    assign rt_s     = bus.instr[20:16];
    assign rd_s     = bus.instr[15:11];
    assign shamt_s  = bus.instr[10:6];
    assign funct_s  = bus.instr[5:0];
    assign imm_s    = bus.instr[15:0];
    assign accept_s = bus.instr_valid & ~bus.stall & ~halt_r;

    // Decode the IF/ID instruction into the next ID/EX bundle.
    always_comb begin
        dec_s        = '0;
        dec_s.valid  = 1'b1;
        dec_s.pc_sel = 2'b11;
        dec_s.alu_op = ALU_ADD;
        dec_s.rsel1  = rs_s;
        dec_s.rsel2  = rt_s;
        dec_s.imm    = {{16{imm_s[15]}}, imm_s};
        dec_s.npc    = bus.npc;
        ill_s        = 1'b0;
        halt_op_s    = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_s.wsel      = rd_s;
                dec_s.reg_write = 1'b1;
                dec_s.imm       = 32'h0000_0000;
                case (funct_s)
                    F_SLL:          begin dec_s.alu_op = ALU_SLL; dec_s.alu_src = 1'b1; dec_s.imm = {27'd0, shamt_s}; end
                    F_SRL:          begin dec_s.alu_op = ALU_SRL; dec_s.alu_src = 1'b1; dec_s.imm = {27'd0, shamt_s}; end
                    F_JR:           begin dec_s.reg_write = 1'b0; dec_s.wsel = 5'd0; dec_s.pc_sel = 2'b10; end
                    F_ADD, F_ADDU:  dec_s.alu_op = ALU_ADD;
                    F_SUB, F_SUBU:  dec_s.alu_op = ALU_SUB;
                    F_AND:          dec_s.alu_op = ALU_AND;
                    F_OR:           dec_s.alu_op = ALU_OR;
                    F_XOR:          dec_s.alu_op = ALU_XOR;
                    F_NOR:          dec_s.alu_op = ALU_NOR;
                    F_SLT:          dec_s.alu_op = ALU_SLT;
                    F_SLTU:         dec_s.alu_op = ALU_SLTU;
                    default:        ill_s = 1'b1;
                endcase
            end
            OP_J, OP_JAL: begin
                // Jump target bits are not register fields; keep the hazard unit quiet.
                dec_s.rsel1  = 5'd0;
                dec_s.rsel2  = 5'd0;
                dec_s.pc_sel = 2'b00;
                dec_s.imm    = {6'd0, bus.instr[25:0]};
                if (opcode_s == OP_JAL) begin
                    dec_s.wsel      = 5'd31;
                    dec_s.wdata_src = 1'b1;
                    dec_s.reg_write = 1'b1;
                end else begin
                    dec_s.wsel      = 5'd0;
                end
            end
            OP_BEQ, OP_BNE: begin
                dec_s.branch     = 1'b1;
                dec_s.branch_sel = (opcode_s == OP_BNE);
                dec_s.pc_sel     = 2'b01;
                dec_s.alu_op     = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_s.wsel      = rt_s;
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                case (opcode_s)
                    OP_SLTI:  dec_s.alu_op = ALU_SLT;
                    OP_SLTIU: dec_s.alu_op = ALU_SLTU;
                    OP_ANDI:  begin dec_s.alu_op = ALU_AND; dec_s.imm = {16'h0000, imm_s}; end
                    OP_ORI:   begin dec_s.alu_op = ALU_OR;  dec_s.imm = {16'h0000, imm_s}; end
                    OP_XORI:  begin dec_s.alu_op = ALU_XOR; dec_s.imm = {16'h0000, imm_s}; end
                    OP_LUI:   begin dec_s.rsel1 = 5'd0; dec_s.imm = {imm_s, 16'h0000}; end
                    default:  dec_s.alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LL, OP_LBU, OP_LHU: begin
                dec_s.wsel      = rt_s;
                dec_s.reg_write = 1'b1;
                dec_s.memto_reg = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.dren      = 1'b1;
                dec_s.datomic   = (opcode_s == OP_LL);
                if (opcode_s == OP_LBU || opcode_s == OP_LHU) begin
                    dec_s.memsize = (opcode_s == OP_LBU) ? 2'b10 : 2'b01;
                    ill_s         = ~SUBWORD_EN;
                end else begin
                    dec_s.memsize = 2'b00;
                end
            end
            OP_SW, OP_SB, OP_SH: begin
                dec_s.alu_src = 1'b1;
                dec_s.dwen    = 1'b1;
                if (opcode_s != OP_SW) begin
                    dec_s.memsize = (opcode_s == OP_SB) ? 2'b10 : 2'b01;
                    ill_s         = ~SUBWORD_EN;
                end else begin
                    dec_s.memsize = 2'b00;
                end
            end
            OP_SC: begin
                // SC writes its success flag back to rt through the memory return path.
                dec_s.wsel      = rt_s;
                dec_s.reg_write = 1'b1;
                dec_s.memto_reg = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.dwen      = 1'b1;
                dec_s.datomic   = 1'b1;
            end
            OP_HALT:  halt_op_s = 1'b1;
            default:  ill_s     = 1'b1;
        endcase
        if (ill_s) begin
            dec_s       = bubble_f();
            dec_s.valid = 1'b1;
            dec_s.npc   = bus.npc;
        end else begin
            dec_s.reg_write = dec_s.reg_write & (dec_s.wsel != 5'd0);
        end
    end

    // ID/EX slot: flush beats stall beats accept; anything else is a bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_r <= bubble_f();
        end else if (bus.flush) begin
            idex_r <= bubble_f();
        end else if (bus.stall) begin
            idex_r <= idex_r;
        end else if (accept_s) begin
            idex_r <= dec_s;
        end else begin
            idex_r <= bubble_f();
        end
    end

    // Sticky halt/illegal flags and the saturating illegal counter, moved only by accepts.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_r    <= 1'b0;
            ill_r     <= 1'b0;
            ill_cnt_r <= '0;
        end else begin
            if (accept_s && halt_op_s) begin
                halt_r <= 1'b1;
            end
            if (accept_s && ill_s) begin
                ill_r <= 1'b1;
                if (ill_cnt_r != {ILL_CNT_W{1'b1}}) begin
                    ill_cnt_r <= ill_cnt_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.id_rsel1      = dec_s.rsel1;
    assign bus.id_rsel2      = dec_s.rsel2;
    assign bus.accept        = accept_s;
    assign bus.ex_valid      = idex_r.valid;
    assign bus.ex_regWrite   = idex_r.reg_write;
    assign bus.ex_memtoReg   = idex_r.memto_reg;
    assign bus.ex_aluSrc     = idex_r.alu_src;
    assign bus.ex_wdataSrc   = idex_r.wdata_src;
    assign bus.ex_branch     = idex_r.branch;
    assign bus.ex_branchSel  = idex_r.branch_sel;
    assign bus.ex_datomic    = idex_r.datomic;
    assign bus.ex_dREN       = idex_r.dren;
    assign bus.ex_dWEN       = idex_r.dwen;
    assign bus.ex_PCSel      = idex_r.pc_sel;
    assign bus.ex_ALUop      = idex_r.alu_op;
    assign bus.ex_rsel1      = idex_r.rsel1;
    assign bus.ex_rsel2      = idex_r.rsel2;
    assign bus.ex_wsel       = idex_r.wsel;
    assign bus.ex_immediate  = idex_r.imm;
    assign bus.ex_memsize    = idex_r.memsize;
    assign bus.ex_npc        = idex_r.npc;
    assign bus.halt          = halt_r;
    assign bus.illegal       = ill_r;
    assign bus.illegal_count = ill_cnt_r;

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Self-checking bench for pipelined_decode_unit: expected ID/EX bundles are queued as
// instructions are driven and compared after the capturing clock edge.
module tb_pipelined_decode_unit;
    import pipelined_decode_pkg::*;

    typedef struct packed {
        logic [9:0]  flags;   // valid,rw,m2r,asrc,wds,br,brs,dat,dren,dwen
        logic [1:0]  pc_sel;
        logic [3:0]  alu_op;
        logic [4:0]  rsel1;
        logic [4:0]  rsel2;
        logic [4:0]  wsel;
        logic [31:0] imm;
        logic [1:0]  memsize;
        logic [31:0] npc;
    } ex_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_asserts = 0;
    int   n_fail = 0;
    ex_t  exp_q[$];
    int   cnt_q[$];

    pipelined_decode_unit_if #(.ILL_CNT_W(8)) bus ();
    pipelined_decode_unit_if #(.ILL_CNT_W(8)) bus_ns ();

    assign bus_ns.instr       = bus.instr;
    assign bus_ns.instr_valid = bus.instr_valid;
    assign bus_ns.npc         = bus.npc;
    assign bus_ns.stall       = bus.stall;
    assign bus_ns.flush       = bus.flush;

    pipelined_decode_unit #(.SUBWORD_EN(1'b1), .ILL_CNT_W(8)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    pipelined_decode_unit #(.SUBWORD_EN(1'b0), .ILL_CNT_W(8)) dut_ns (.CLK(CLK), .nRST(nRST), .bus(bus_ns));

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [3:0] A_SLL = 4'(ALU_SLL), A_ADD = 4'(ALU_ADD), A_SUB = 4'(ALU_SUB);
    localparam logic [3:0] A_AND = 4'(ALU_AND), A_OR = 4'(ALU_OR);

    function automatic ex_t mk(input logic [9:0] f, input logic [1:0] pc, input logic [3:0] alu,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                               input logic [31:0] imm, input logic [1:0] ms, input logic [31:0] npc);
        ex_t e;
        e.flags = f; e.pc_sel = pc; e.alu_op = alu; e.rsel1 = r1; e.rsel2 = r2; e.wsel = w;
        e.imm = imm; e.memsize = ms; e.npc = npc;
        return e;
    endfunction

    function automatic ex_t sample();
        ex_t s;
        s.flags   = {bus.ex_valid, bus.ex_regWrite, bus.ex_memtoReg, bus.ex_aluSrc, bus.ex_wdataSrc,
                     bus.ex_branch, bus.ex_branchSel, bus.ex_datomic, bus.ex_dREN, bus.ex_dWEN};
        s.pc_sel  = bus.ex_PCSel;
        s.alu_op  = 4'(bus.ex_ALUop);
        s.rsel1   = bus.ex_rsel1;
        s.rsel2   = bus.ex_rsel2;
        s.wsel    = bus.ex_wsel;
        s.imm     = bus.ex_immediate;
        s.memsize = bus.ex_memsize;
        s.npc     = bus.ex_npc;
        return s;
    endfunction

    task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f,
                         input logic [31:0] pc);
        bus.instr = i; bus.instr_valid = v; bus.stall = s; bus.flush = f; bus.npc = pc;
    endtask

    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge CLK); nRST = 1'b0;
        @(negedge CLK); @(negedge CLK); nRST = 1'b1;
    endtask

    task automatic test_reset();
        ex_t got, e;
        drive(32'h2002FFFF, 1'b1, 1'b0, 1'b0, 32'h100);
        nRST = 1'b0;
        exp_q.push_back(mk(10'b0, 2'b11, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 32'h0));
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL reset_bundle: got %h required %h", got, e); end
        n_asserts++;
        if ({bus.halt, bus.illegal, bus.illegal_count} !== 10'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b/%b/%0d required 0/0/0", bus.halt, bus.illegal, bus.illegal_count);
        end
        nRST = 1'b1;
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1 n_asserts++;
        if (bus.ex_valid !== 1'b0 || bus.ex_PCSel !== 2'b11) begin
            n_fail++; $display("FAIL async_reset: got valid %b pcsel %b required 0 11", bus.ex_valid, bus.ex_PCSel);
        end
    endtask

    task automatic test_addi();
        ex_t got, e;
        do_reset();
        drive(32'h2002FFFF, 1'b1, 1'b0, 1'b0, 32'h0040_0004);
        exp_q.push_back(mk(10'b1101000000, 2'b11, A_ADD, 5'd0, 5'd2, 5'd2, 32'hFFFF_FFFF, 2'b00, 32'h0040_0004));
        #1 n_asserts++;
        if (bus.id_rsel1 !== 5'd0 || bus.id_rsel2 !== 5'd2 || bus.accept !== 1'b1) begin
            n_fail++; $display("FAIL addi_comb: got rsel %0d,%0d accept %b required 0,2 1", bus.id_rsel1, bus.id_rsel2, bus.accept);
        end
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL addi: got %h required %h", got, e); end
    endtask

    task automatic test_stall();
        ex_t got, e, held;
        held = mk(10'b1101000000, 2'b11, A_ADD, 5'd0, 5'd2, 5'd2, 32'hFFFF_FFFF, 2'b00, 32'h0040_0004);
        for (int c = 0; c < 3; c++) begin
            drive(32'h34038000, 1'b1, 1'b1, 1'b0, 32'h0040_0008);
            exp_q.push_back(held);
            #1 n_asserts++;
            if (bus.accept !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got %b required 0 (cycle %0d)", bus.accept, c); end
            @(negedge CLK);
            got = sample(); e = exp_q.pop_front(); n_asserts++;
            if (got !== e) begin n_fail++; $display("FAIL stall_hold: got %h required %h (cycle %0d)", got, e, c); end
        end
        drive(32'h34038000, 1'b1, 1'b0, 1'b0, 32'h0040_0008);
        exp_q.push_back(mk(10'b1101000000, 2'b11, A_OR, 5'd0, 5'd3, 5'd3, 32'h0000_8000, 2'b00, 32'h0040_0008));
        #1 n_asserts++;
        if (bus.accept !== 1'b1) begin n_fail++; $display("FAIL ori_accept: got %b required 1", bus.accept); end
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL ori: got %h required %h", got, e); end
        drive(32'h34038000, 1'b0, 1'b0, 1'b0, 32'h0040_000C);
        exp_q.push_back(mk(10'b0, 2'b11, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 32'h0));
        #1 n_asserts++;
        if (bus.accept !== 1'b0) begin n_fail++; $display("FAIL idle_accept: got %b required 0", bus.accept); end
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL idle_bubble: got %h required %h", got, e); end
    endtask

    task automatic test_subword();
        ex_t got, e;
        do_reset();
        drive(32'h90430004, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
        exp_q.push_back(mk(10'b1111000010, 2'b11, A_ADD, 5'd2, 5'd3, 5'd3, 32'h4, 2'b10, 32'h0000_0010));
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL lbu: got %h required %h", got, e); end
        n_asserts++;
        if ({bus_ns.ex_valid, bus_ns.ex_regWrite, bus_ns.ex_dREN, bus_ns.ex_PCSel} !== 5'b10011) begin
            n_fail++; $display("FAIL lbu_nosub: got v/rw/dren/pc %b%b%b%b required 10011", bus_ns.ex_valid, bus_ns.ex_regWrite, bus_ns.ex_dREN, bus_ns.ex_PCSel);
        end
        drive(32'hA4430006, 1'b1, 1'b0, 1'b0, 32'h0000_0014);
        exp_q.push_back(mk(10'b1001000001, 2'b11, A_ADD, 5'd2, 5'd3, 5'd0, 32'h6, 2'b01, 32'h0000_0014));
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL sh: got %h required %h", got, e); end
        n_asserts++;
        if ({bus_ns.ex_valid, bus_ns.ex_dWEN, bus_ns.ex_PCSel} !== 4'b1011) begin
            n_fail++; $display("FAIL sh_nosub: got v/dwen/pc %b%b%b required 1011", bus_ns.ex_valid, bus_ns.ex_dWEN, bus_ns.ex_PCSel);
        end
        n_asserts++;
        if (bus_ns.illegal !== 1'b1 || bus_ns.illegal_count !== 8'd2) begin
            n_fail++; $display("FAIL nosub_count: got %b/%0d required 1/2", bus_ns.illegal, bus_ns.illegal_count);
        end
        n_asserts++;
        if (bus.illegal !== 1'b0 || bus.illegal_count !== 8'd0) begin
            n_fail++; $display("FAIL sub_count: got %b/%0d required 0/0", bus.illegal, bus.illegal_count);
        end
    endtask

    task automatic test_back_to_back();
        ex_t got, e;
        logic [31:0] ins[9];
        ex_t tbl[9];
        ins[0] = 32'h0C000010; tbl[0] = mk(10'b1100100000, 2'b00, A_ADD, 5'd0, 5'd0, 5'd31, 32'h10, 2'b00, 32'h0);
        ins[1] = 32'h10220003; tbl[1] = mk(10'b1000010000, 2'b01, A_SUB, 5'd1, 5'd2, 5'd0, 32'h3, 2'b00, 32'h0);
        ins[2] = 32'h1422FFFF; tbl[2] = mk(10'b1000011000, 2'b01, A_SUB, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 2'b00, 32'h0);
        ins[3] = 32'h3C051234; tbl[3] = mk(10'b1101000000, 2'b11, A_ADD, 5'd0, 5'd5, 5'd5, 32'h1234_0000, 2'b00, 32'h0);
        ins[4] = 32'h000220C0; tbl[4] = mk(10'b1101000000, 2'b11, A_SLL, 5'd0, 5'd2, 5'd4, 32'h3, 2'b00, 32'h0);
        ins[5] = 32'h03E00008; tbl[5] = mk(10'b1000000000, 2'b10, A_ADD, 5'd31, 5'd0, 5'd0, 32'h0, 2'b00, 32'h0);
        ins[6] = 32'hAC430008; tbl[6] = mk(10'b1001000001, 2'b11, A_ADD, 5'd2, 5'd3, 5'd0, 32'h8, 2'b00, 32'h0);
        ins[7] = 32'h3026FFFF; tbl[7] = mk(10'b1101000000, 2'b11, A_AND, 5'd1, 5'd6, 5'd6, 32'h0000_FFFF, 2'b00, 32'h0);
        ins[8] = 32'hE0240000; tbl[8] = mk(10'b1111000101, 2'b11, A_ADD, 5'd1, 5'd4, 5'd4, 32'h0, 2'b00, 32'h0);
        for (int k = 0; k < 9; k++) begin
            drive(ins[k], 1'b1, 1'b0, 1'b0, 32'h0040_0100 + 32'(4 * k));
            e = tbl[k]; e.npc = 32'h0040_0100 + 32'(4 * k);
            exp_q.push_back(e);
            @(negedge CLK);
            got = sample(); e = exp_q.pop_front(); n_asserts++;
            if (got !== e) begin n_fail++; $display("FAIL b2b[%0d] %h: got %h required %h", k, ins[k], got, e); end
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(32'h1C000000, 1'b1, 1'b0, 1'b0, 32'h0);
            cnt_q.push_back((k + 1 > 255) ? 255 : k + 1);
            @(negedge CLK);
            exp_cnt = cnt_q.pop_front(); n_asserts++;
            if (int'(bus.illegal_count) !== exp_cnt || bus.illegal !== 1'b1) begin
                n_fail++; $display("FAIL ill_count[%0d]: got %0d/%b required %0d/1", k, bus.illegal_count, bus.illegal, exp_cnt);
            end
            if (k == 0) begin
                n_asserts++;
                if ({bus.ex_valid, bus.ex_regWrite, bus.ex_dREN, bus.ex_dWEN, bus.ex_PCSel} !== 6'b100011) begin
                    n_fail++; $display("FAIL ill_nop: got v/rw/dren/dwen/pc %b%b%b%b%b required 100011", bus.ex_valid, bus.ex_regWrite, bus.ex_dREN, bus.ex_dWEN, bus.ex_PCSel);
                end
            end
        end
    endtask

    task automatic test_halt();
        ex_t got, e;
        do_reset();
        drive(32'hFC000000, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
        @(negedge CLK);
        n_asserts++;
        if ({bus.ex_valid, bus.ex_regWrite, bus.ex_dREN, bus.ex_dWEN, bus.halt} !== 5'b10001) begin
            n_fail++; $display("FAIL halt_load: got v/rw/dren/dwen/halt %b%b%b%b%b required 10001", bus.ex_valid, bus.ex_regWrite, bus.ex_dREN, bus.ex_dWEN, bus.halt);
        end
        for (int c = 0; c < 4; c++) begin
            drive(32'h00430820, 1'b1, 1'b0, (c == 0), 32'h0000_0204);
            #1 n_asserts++;
            if (bus.accept !== 1'b0) begin n_fail++; $display("FAIL halted_accept: got %b required 0 (cycle %0d)", bus.accept, c); end
            @(negedge CLK);
            n_asserts++;
            if (bus.ex_valid !== 1'b0 || bus.halt !== 1'b1) begin
                n_fail++; $display("FAIL halted_slot: got valid %b halt %b required 0 1 (cycle %0d)", bus.ex_valid, bus.halt, c);
            end
        end
        nRST = 1'b0;
        #1 n_asserts++;
        if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b required 0", bus.halt); end
        @(negedge CLK);
        nRST = 1'b1;
        exp_q.push_back(mk(10'b1100000000, 2'b11, A_ADD, 5'd2, 5'd3, 5'd1, 32'h0, 2'b00, 32'h0000_0204));
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL add_after_halt: got %h required %h", got, e); end
    endtask

    task automatic test_zero_flush();
        ex_t got, e, bub;
        bub = mk(10'b0, 2'b11, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 32'h0);
        do_reset();
        drive(32'h00220021, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
        exp_q.push_back(mk(10'b1000000000, 2'b11, A_ADD, 5'd1, 5'd2, 5'd0, 32'h0, 2'b00, 32'h0000_0300));
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL addu_r0: got %h required %h", got, e); end
        drive(32'h00430820, 1'b1, 1'b1, 1'b1, 32'h0000_0304);
        exp_q.push_back(bub);
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e) begin n_fail++; $display("FAIL flush_stall: got %h required %h", got, e); end
        drive(32'h1C000000, 1'b1, 1'b0, 1'b1, 32'h0000_0308);
        exp_q.push_back(bub);
        @(negedge CLK);
        got = sample(); e = exp_q.pop_front(); n_asserts++;
        if (got !== e || bus.illegal !== 1'b1 || bus.illegal_count !== 8'd1) begin
            n_fail++; $display("FAIL flush_illegal: got %h %b/%0d required %h 1/1", got, bus.illegal, bus.illegal_count, e);
        end
        drive(32'h1C000000, 1'b1, 1'b1, 1'b0, 32'h0000_030C);
        @(negedge CLK);
        n_asserts++;
        if (bus.illegal_count !== 8'd1) begin n_fail++; $display("FAIL stalled_illegal: got %0d required 1", bus.illegal_count); end
    endtask

    initial begin
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_addi();
        test_stall();
        test_subword();
        test_back_to_back();
        test_saturate();
        test_halt();
        test_zero_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
